// File: rtl/mux_rr_arb_if.sv
// Handshake bundle for mux_rr_arb: N input channels in, one registered beat out.
// slave = arbiter view (drives in_ready/out_*), master = source/sink view.
interface mux_rr_arb_if #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
);
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;

  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_rr_arb.sv
// N-to-1 arbitrating mux with one registered output beat; MODE 0 round-robin,
// MODE 1 explicit sel. Ports: clk, rst (sync, active-high), bus (slave modport).
module mux_rr_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0
) (
  input logic          clk,
  input logic          rst,
  mux_rr_arb_if.slave  bus
);
  localparam int SW = $clog2(N);

  logic [SW-1:0] ptr;
  logic [W-1:0]  data_q;
  logic [SW-1:0] chan_q;
  logic          valid_q;

  logic          load;
  logic          found;
  logic [SW-1:0] gidx;
  logic [N-1:0]  gnt;
  logic          accept;

  assign load = !valid_q || bus.out_ready;

  always_comb begin
    found = 1'b0;
    gidx  = '0;
    if (MODE == 0) begin
      // Scan from ptr upward, first valid wins.
      for (int k = 0; k < N; k++) begin
        int c;
        c = (int'(ptr) + k) % N;
        if (!found && bus.in_valid[c]) begin
          found = 1'b1;
          gidx  = SW'(c);
        end
      end
    end else begin
      // Out-of-range selects never accept.
      if (int'(bus.sel) < N) begin
        found = bus.in_valid[bus.sel];
        gidx  = bus.sel;
      end
    end
    gnt = found ? (N'(1) << gidx) : '0;
  end

  assign accept       = found && load && !rst;
  assign bus.in_ready = (load && !rst) ? gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      chan_q  <= '0;
      ptr     <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= bus.in_data[gidx*W +: W];
      chan_q  <= gidx;
      if (MODE == 0)
        ptr <= (gidx == SW'(N-1)) ? '0 : gidx + 1'b1;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: round-robin instance (a) and select instance (b).
// Inputs change on the falling edge; checks run after combinational settle.
module tb_mux_rr_arb;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux_rr_arb_if #(.N(4), .W(8)) a ();
  mux_rr_arb_if #(.N(4), .W(8)) b ();

  mux_rr_arb #(.N(4), .W(8), .MODE(0)) dut_rr (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  mux_rr_arb #(.N(4), .W(8), .MODE(1)) dut_sel (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a.in_valid  = 4'b1111;
    a.in_data   = 32'h44332211;
    a.out_ready = 1'b1;
    a.sel       = '0;
    b.in_valid  = 4'b0000;
    b.in_data   = '0;
    b.out_ready = 1'b1;
    b.sel       = '0;

    tick();
    tick();
    check("rst_valid", 32'(a.out_valid), 32'd0);
    check("rst_data", 32'(a.out_data), 32'h00);
    check("rst_ready", 32'(a.in_ready), 32'b0000);

    rst = 1'b0;
    #1;
    check("first_grant", 32'(a.in_ready), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      int c;
      c = i % 4;
      tick();
      check("rr_chan", 32'(a.out_chan), 32'(c));
      check("rr_data", 32'(a.out_data), 32'h11 * (c + 1));
      check("rr_valid", 32'(a.out_valid), 32'd1);
    end

    a.out_ready = 1'b0;
    #1;
    check("bp_ready0", 32'(a.in_ready), 32'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_data", 32'(a.out_data), 32'h11);
      check("bp_chan", 32'(a.out_chan), 32'd0);
      check("bp_ready", 32'(a.in_ready), 32'b0000);
    end
    a.out_ready = 1'b1;
    #1;
    check("bp_release", 32'(a.in_ready), 32'b0010);
    tick();
    check("bp_next_chan", 32'(a.out_chan), 32'd1);
    check("bp_next_data", 32'(a.out_data), 32'h22);

    a.in_valid = 4'b1010;
    #1;
    check("skip_grant3", 32'(a.in_ready), 32'b1000);
    tick();
    check("skip_chan3", 32'(a.out_chan), 32'd3);
    check("skip_data3", 32'(a.out_data), 32'h44);
    check("wrap_grant1", 32'(a.in_ready), 32'b0010);
    tick();
    check("wrap_chan1", 32'(a.out_chan), 32'd1);
    check("wrap_data1", 32'(a.out_data), 32'h22);

    a.in_valid = 4'b0000;
    #1;
    check("idle_ready", 32'(a.in_ready), 32'b0000);
    tick();
    check("drain_valid", 32'(a.out_valid), 32'd0);
    tick();
    check("idle_valid", 32'(a.out_valid), 32'd0);
    check("idle_chan", 32'(a.out_chan), 32'd1);

    a.in_valid  = 4'b0001;
    a.out_ready = 1'b0;
    #1;
    check("empty_load", 32'(a.in_ready), 32'b0001);
    tick();
    check("mid_valid", 32'(a.out_valid), 32'd1);
    check("mid_chan", 32'(a.out_chan), 32'd0);
    a.in_valid = 4'b1111;
    #1;
    check("mid_hold", 32'(a.in_ready), 32'b0000);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 32'(a.out_valid), 32'd0);
    check("mid_rst_ready", 32'(a.in_ready), 32'b0000);
    rst = 1'b0;
    a.out_ready = 1'b1;
    #1;
    check("post_rst_grant", 32'(a.in_ready), 32'b0001);
    tick();
    check("post_rst_chan", 32'(a.out_chan), 32'd0);
    check("post_rst_data", 32'(a.out_data), 32'h11);

    b.sel      = 2'd2;
    b.in_valid = 4'b0100;
    b.in_data  = 32'h00A50000;
    #1;
    check("sel_grant", 32'(b.in_ready), 32'b0100);
    tick();
    check("sel_chan", 32'(b.out_chan), 32'd2);
    check("sel_data", 32'(b.out_data), 32'hA5);
    check("sel_valid", 32'(b.out_valid), 32'd1);
    b.in_valid = 4'b1011;
    #1;
    check("sel_noacc", 32'(b.in_ready), 32'b0000);
    tick();
    check("sel_drain", 32'(b.out_valid), 32'd0);
    check("sel_keep", 32'(b.out_data), 32'hA5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mux_rr_arb.md
MUX_RR_ARB -- requirements
Module: mux_rr_arb

Interface
REQ-001 SHALL have parameter N, default 4, number of input channels (legal 2..16).
REQ-002 SHALL have parameter W, default 8, data width per channel (legal 1..64).
REQ-003 SHALL have parameter MODE, default 0, where 0 is round-robin arbitration and 1 is an explicit select via sel.
REQ-004 SHALL define SW = $clog2(N) as an internal width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port in_data, input, N*W bits: channel i occupies bits [i*W +: W].
REQ-008 SHALL have port in_valid, input, N bits: per-channel valid.
REQ-009 SHALL have port in_ready, output, N bits: per-channel ready (combinational).
REQ-010 SHALL have port sel, input, SW bits: channel select, used only when MODE=1.
REQ-011 SHALL have port out_data, output, W bits: registered selected data.
REQ-012 SHALL have port out_chan, output, SW bits: registered index of the source channel.
REQ-013 SHALL have port out_valid, output, 1 bit: the output register holds a beat.
REQ-014 SHALL have port out_ready, input, 1 bit: the downstream accepts the beat.

Function
REQ-015 SHALL complete a transfer on a channel or the output only on a rising edge where valid && ready.
REQ-016 SHALL assert the load enable, load = !out_valid || out_ready.
REQ-017 SHALL assert in_ready[i] = load && grant[i]; at most one grant bit is high per cycle.
REQ-018 SHALL, in MODE=0, grant the first channel with in_valid high, searching from ptr upward, modulo N.
REQ-019 SHALL, in MODE=0, update ptr to (granted index + 1) mod N only on an accepted input transfer; ptr = N-1 SHALL wrap to 0.
REQ-020 SHALL, in MODE=1, set grant[sel] = in_valid[sel] with all other grants 0; ptr is unused.
REQ-021 SHALL, in MODE=1, accept no input when sel >= N.
REQ-022 SHALL, on an accepted input, register out_data = the channel's word, out_chan = its index, and out_valid = 1 at the next edge (1-cycle latency).
REQ-023 SHALL clear out_valid when out_valid && out_ready and no input is accepted in the same cycle.
REQ-024 SHALL hold out_data and out_chan when out_valid=1 and out_ready=0; all in_ready SHALL be 0 then.
REQ-025 SHALL, on simultaneous output drain and input accept, replace the beat, keep out_valid=1, and sustain throughput of 1 beat per cycle.
REQ-026 SHALL produce no grant and no state change when no in_valid is high.
REQ-027 SHALL NOT let in_data or in_valid of ungranted channels affect any state.
REQ-028 SHALL never let a continuously valid channel wait more than N-1 accepted transfers in MODE=0.

Reset
REQ-029 SHALL set out_valid=0, out_data=0, out_chan=0 and ptr=0 at the first edge with rst=1.
REQ-030 SHALL hold in_ready at 0 while rst=1.
REQ-031 SHALL discard a beat held in the output register when rst asserts mid-operation; no transfer occurs in that cycle.
REQ-032 SHALL make arbitration after rst deasserts start from channel 0.

Verification (N=4, W=8)
REQ-033 SHALL cover reset: rst=1 for 2 cycles with all valids high -> out_valid=0, out_data=0x00, in_ready=4'b0000.
REQ-034 SHALL cover MODE=0 fairness: all 4 valids high, out_ready=1, in_data={0x44,0x33,0x22,0x11} -> out_chan sequence 0,1,2,3,0 with out_data 0x11,0x22,0x33,0x44,0x11 on consecutive cycles.
REQ-035 SHALL cover MODE=0 backpressure: one beat out, out_ready=0 for 3 cycles -> out_data stable, in_ready=0000; out_ready=1 -> next channel is granted in the same cycle.
REQ-036 SHALL cover MODE=0 skip and wrap: only ch1 and ch3 valid, ptr=2 -> grants ch3, then ch1 (ptr wraps 0 to 1).
REQ-037 SHALL cover MODE=1 select: sel=2 with in_valid=0100, data 0xA5 -> next cycle out_chan=2, out_data=0xA5; sel=2 with in_valid=1011 -> no accept and out_valid drops after drain.
REQ-038 SHALL cover reset mid-stream: rst for 1 cycle while out_valid=1, out_ready=0 -> out_valid=0 next cycle; the first grant afterwards is the lowest valid channel.
